sub_result_skid_stage: RTL and testbench

//   Registered valid/ready output stage placed directly downstream of the 32-bit

---
 rtl/sub_result_skid_stage.sv | 145 ++++++++++++++
 tb/tb_sub_result_skid_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sub_result_skid_stage.sv
// Registered valid/ready output stage behind the 32-bit subtractor.
// Holds up to two results (head + skid) so in_ready comes straight from a flop.
// Optionally clamps overflowed differences to the signed limit on entry, and
// tracks a sticky overflow flag plus a saturating overflow event counter.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1; valid never depends combinationally on ready, and once out_valid is
// raised out_data/out_ovf are held until the downstream accepts them.
module sub_result_skid_stage #(
   parameter int WIDTH    = 32,
   parameter bit SATURATE = 1'b1,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_diff,
   input  logic             in_overflow,
   input  logic             in_a_sign,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_ovf,
   input  logic             clr_sticky,
   output logic             sticky_ovf,
   output logic [CNT_W-1:0] ovf_count,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic [WIDTH-1:0] head_data_q, head_data_d;
   logic             head_ovf_q, head_ovf_d;
   logic [WIDTH-1:0] skid_data_q, skid_data_d;
   logic             skid_ovf_q, skid_ovf_d;
   logic             sticky_q, sticky_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             in_xfer;
   logic             out_xfer;
   logic [WIDTH-1:0] entry_data;

   assign in_ready   = in_ready_q;
   assign out_valid  = (state_q != S_EMPTY);
   assign out_data   = head_data_q;
   assign out_ovf    = head_ovf_q;
   assign sticky_ovf = sticky_q;
   assign ovf_count  = cnt_q;
   assign state_dbg  = state_q;

   assign in_xfer  = in_valid & in_ready_q;
   assign out_xfer = out_valid & out_ready;

   // Clamp an overflowed difference toward the sign of operand a on entry.
   always_comb begin
      entry_data = in_diff;
      if (SATURATE && in_overflow) begin
         entry_data = in_a_sign ? MAX_NEG : MAX_POS;
      end
   end

   // Occupancy FSM: next state, buffer moves and registered in_ready.
   always_comb begin
      state_d     = state_q;
      head_data_d = head_data_q;
      head_ovf_d  = head_ovf_q;
      skid_data_d = skid_data_q;
      skid_ovf_d  = skid_ovf_q;
      case (state_q)
         S_EMPTY: begin
            if (in_xfer) begin
               head_data_d = entry_data;
               head_ovf_d  = in_overflow;
               state_d     = S_ONE;
            end
         end
         S_ONE: begin
            if (in_xfer && out_xfer) begin
               head_data_d = entry_data;
               head_ovf_d  = in_overflow;
            end else if (in_xfer) begin
               skid_data_d = entry_data;
               skid_ovf_d  = in_overflow;
               state_d     = S_TWO;
            end else if (out_xfer) begin
               state_d = S_EMPTY;
            end
         end
         S_TWO: begin
            // in_ready is low here, so only the pop can happen.
            if (out_xfer) begin
               head_data_d = skid_data_q;
               head_ovf_d  = skid_ovf_q;
               state_d     = S_ONE;
            end
         end
         default: state_d = S_EMPTY;
      endcase
      in_ready_d = (state_d != S_TWO);
   end

   // Sticky flag (set wins over clear) and saturating overflow counter.
   always_comb begin
      sticky_d = (sticky_q & ~clr_sticky) | (in_xfer & in_overflow);
      cnt_d    = cnt_q;
      if (in_xfer && in_overflow && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State and datapath registers; reset drops any buffered entries.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_EMPTY;
         in_ready_q  <= 1'b1;
         head_data_q <= '0;
         head_ovf_q  <= 1'b0;
         skid_data_q <= '0;
         skid_ovf_q  <= 1'b0;
         sticky_q    <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         head_data_q <= head_data_d;
         head_ovf_q  <= head_ovf_d;
         skid_data_q <= skid_data_d;
         skid_ovf_q  <= skid_ovf_d;
         sticky_q    <= sticky_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule

// File: tb/tb_sub_result_skid_stage.sv
// Directed bench for sub_result_skid_stage (SATURATE=1, CNT_W=2).
module tb_sub_result_skid_stage;

   localparam int WIDTH = 32;
   localparam int CNT_W = 2;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_diff;
   logic             in_overflow;
   logic             in_a_sign;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_ovf;
   logic             clr_sticky;
   logic             sticky_ovf;
   logic [CNT_W-1:0] ovf_count;
   logic [1:0]       state_dbg;

   int n_cmp = 0;
   int n_err = 0;

   sub_result_skid_stage #(
      .WIDTH(WIDTH),
      .SATURATE(1'b1),
      .CNT_W(CNT_W)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_diff    (in_diff),
      .in_overflow(in_overflow),
      .in_a_sign  (in_a_sign),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_ovf    (out_ovf),
      .clr_sticky (clr_sticky),
      .sticky_ovf (sticky_ovf),
      .ovf_count  (ovf_count),
      .state_dbg  (state_dbg)
   );

   // Clock: 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle before sampling/driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic o, input logic s);
      in_valid    = v;
      in_diff     = d;
      in_overflow = o;
      in_a_sign   = s;
   endtask

   initial begin
      rst = 1'b1;
      out_ready = 1'b0;
      clr_sticky = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
      chk("rst_sticky", {31'd0, sticky_ovf}, 32'd0);
      chk("rst_count", {30'd0, ovf_count}, 32'd0);

      // Plain pass-through of 5.
      out_ready = 1'b1;
      drive(1'b1, 32'h0000_0005, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      chk("pass_valid", {31'd0, out_valid}, 32'd1);
      chk("pass_data", out_data, 32'h0000_0005);
      chk("pass_ovf", {31'd0, out_ovf}, 32'd0);
      chk("pass_sticky", {31'd0, sticky_ovf}, 32'd0);
      chk("pass_count", {30'd0, ovf_count}, 32'd0);
      tick();
      chk("pass_drained", {31'd0, out_valid}, 32'd0);

      // Positive overflow clamps to MAX_POS.
      drive(1'b1, 32'h8000_0000, 1'b1, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      chk("satp_data", out_data, 32'h7FFF_FFFF);
      chk("satp_ovf", {31'd0, out_ovf}, 32'd1);
      chk("satp_sticky", {31'd0, sticky_ovf}, 32'd1);
      chk("satp_count", {30'd0, ovf_count}, 32'd1);
      tick();

      // Negative overflow clamps to MAX_NEG; clear in same cycle loses to set.
      drive(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
      clr_sticky = 1'b1;
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      clr_sticky = 1'b0;
      chk("satn_data", out_data, 32'h8000_0000);
      chk("satn_sticky_setwins", {31'd0, sticky_ovf}, 32'd1);
      chk("satn_count", {30'd0, ovf_count}, 32'd2);
      tick();

      // Clear with no overflow; counter unaffected.
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      chk("clr_sticky", {31'd0, sticky_ovf}, 32'd0);
      chk("clr_count_kept", {30'd0, ovf_count}, 32'd2);

      // Back-pressure: push A, B, C with out_ready low.
      out_ready = 1'b0;
      drive(1'b1, 32'h0000_00AA, 1'b0, 1'b0);
      tick();
      chk("bp_a_ready", {31'd0, in_ready}, 32'd1);
      chk("bp_a_data", out_data, 32'h0000_00AA);
      drive(1'b1, 32'h0000_00BB, 1'b0, 1'b0);
      tick();
      chk("bp_b_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_b_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_b_data", out_data, 32'h0000_00AA);
      drive(1'b1, 32'h0000_00CC, 1'b0, 1'b0);
      tick();
      chk("bp_c_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_data", out_data, 32'h0000_00AA);
      out_ready = 1'b1;
      tick();
      chk("bp_pop_b", out_data, 32'h0000_00BB);
      chk("bp_pop_ready", {31'd0, in_ready}, 32'd1);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      chk("bp_pop_c", out_data, 32'h0000_00CC);
      chk("bp_pop_c_valid", {31'd0, out_valid}, 32'd1);
      tick();
      chk("bp_empty", {31'd0, out_valid}, 32'd0);

      // Full throughput: one result per cycle.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h0000_1000 + i, 1'b0, 1'b0);
         tick();
         chk("stream_valid", {31'd0, out_valid}, 32'd1);
         chk("stream_data", out_data, 32'h0000_1000 + i);
      end
      drive(1'b0, '0, 1'b0, 1'b0);
      tick();
      chk("stream_end", {31'd0, out_valid}, 32'd0);

      // Counter saturates at 3 (count already 2).
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'h8000_0000, 1'b1, 1'b0);
         tick();
         chk("cnt_sat", {30'd0, ovf_count}, 32'd3);
      end
      drive(1'b0, '0, 1'b0, 1'b0);
      tick();

      // Fill to two entries, then reset.
      out_ready = 1'b0;
      drive(1'b1, 32'h0000_0001, 1'b1, 1'b0);
      tick();
      drive(1'b1, 32'h0000_0002, 1'b1, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      chk("full_ready", {31'd0, in_ready}, 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst2_valid", {31'd0, out_valid}, 32'd0);
      chk("rst2_ready", {31'd0, in_ready}, 32'd1);
      chk("rst2_sticky", {31'd0, sticky_ovf}, 32'd0);
      chk("rst2_count", {30'd0, ovf_count}, 32'd0);
      chk("rst2_data", out_data, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
